// File: rtl/lsu_core.sv
// lsu_core: multi-cycle load/store engine between execute and data memory.
// Accepts one request at a time, drives an aligned bus request with byte
// mask and lane-shifted store data, then returns extended load data or an
// error code (misaligned, illegal width, timeout) with a one-cycle done pulse.
//
// Handshakes: a request transfers on any clock edge where valid and ready
// are both high (i_idu_req_valid/o_lsu_req_ready, o_mem_valid/i_mem_ready).
// The valid side keeps its payload stable until that edge. i_mem_rvalid is
// a single-cycle response with no back-pressure, accepted only in WAIT.
module lsu_core #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_idu_req_valid,
    output logic                o_lsu_req_ready,
    input  logic                i_idu_wren,
    input  logic [2:0]          i_idu_funct3,
    input  logic [ADDR_W-1:0]   i_exu_addr,
    input  logic [DATA_W-1:0]   i_idu_wdata,
    output logic                o_lsu_done,
    output logic [DATA_W-1:0]   o_lsu_rdata,
    output logic                o_lsu_err,
    output logic [1:0]          o_lsu_err_code,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic                o_mem_wen,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic [1:0]          o_dbg_state
);

    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    // Debug encoding on o_dbg_state: 0 IDLE, 1 REQ, 2 WAIT, 3 DONE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic                wren_q;
    logic [2:0]          f3_q;
    logic [LB-1:0]       lane_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                mem_valid_q;
    logic                mem_wen_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [NB-1:0]       mem_wmask_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                done_q;
    logic                err_q;
    logic [1:0]          err_code_q;

    logic [LB-1:0]       lane_d;
    logic                illegal_d;
    logic                misal_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [NB-1:0]       wmask_d;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   load_d;
    logic                tmo_hit;

    // Request decode: legality, alignment and the bus-side image of the access.
    always_comb begin
        lane_d    = i_exu_addr[LB-1:0];
        illegal_d = (i_idu_funct3 == 3'b111) ||
                    ((i_idu_funct3 == 3'b011) && (DATA_W == 32)) ||
                    ((i_idu_funct3 == 3'b110) && (DATA_W == 32)) ||
                    (i_idu_wren && i_idu_funct3[2]);
        case (i_idu_funct3[1:0])
            2'b01:   misal_d = i_exu_addr[0];
            2'b10:   misal_d = (i_exu_addr[1:0] != 2'b00);
            2'b11:   misal_d = (i_exu_addr[2:0] != 3'b000);
            default: misal_d = 1'b0;
        endcase
        addr_d  = {i_exu_addr[ADDR_W-1:LB], {LB{1'b0}}};
        wdata_d = i_idu_wdata << {lane_d, 3'b000};
        case (i_idu_funct3[1:0])
            2'b00:   wmask_d = NB'(1) << lane_d;
            2'b01:   wmask_d = NB'(3) << lane_d;
            2'b10:   wmask_d = NB'(4'hF) << lane_d;
            default: wmask_d = {NB{1'b1}};
        endcase
        if (!i_idu_wren) begin
            wmask_d = '0;
        end
    end

    // Load extraction: move the addressed bytes to bit 0, then extend by width.
    always_comb begin
        shifted = i_mem_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  load_d = DATA_W'($signed(shifted[7:0]));
            3'b001:  load_d = DATA_W'($signed(shifted[15:0]));
            3'b010:  load_d = DATA_W'($signed(shifted[31:0]));
            3'b100:  load_d = DATA_W'(shifted[7:0]);
            3'b101:  load_d = DATA_W'(shifted[15:0]);
            3'b110:  load_d = DATA_W'(shifted[31:0]);
            default: load_d = shifted;
        endcase
        tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Transaction FSM with registered bus and completion outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            wren_q      <= 1'b0;
            f3_q        <= '0;
            lane_q      <= '0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_idu_req_valid) begin
                        wren_q <= i_idu_wren;
                        f3_q   <= i_idu_funct3;
                        lane_q <= lane_d;
                        cnt_q  <= '0;
                        if (illegal_d) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            err_q      <= 1'b1;
                            err_code_q <= 2'b11;
                        end else if (misal_d) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            err_q      <= 1'b1;
                            err_code_q <= 2'b01;
                        end else begin
                            state_q     <= S_REQ;
                            mem_valid_q <= 1'b1;
                            mem_wen_q   <= i_idu_wren;
                            mem_addr_q  <= addr_d;
                            mem_wdata_q <= wdata_d;
                            mem_wmask_q <= wmask_d;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (tmo_hit) begin
                        state_q     <= S_DONE;
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        err_code_q  <= 2'b10;
                    end else if (i_mem_ready) begin
                        state_q     <= S_WAIT;
                        mem_valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (i_mem_rvalid) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        if (!wren_q) begin
                            rdata_q <= load_d;
                        end
                    end else if (tmo_hit) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    done_q     <= 1'b0;
                    err_q      <= 1'b0;
                    err_code_q <= 2'b00;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_lsu_req_ready = (state_q == S_IDLE) && !i_rst;
    assign o_lsu_done      = done_q;
    assign o_lsu_rdata     = rdata_q;
    assign o_lsu_err       = err_q;
    assign o_lsu_err_code  = err_code_q;
    assign o_mem_valid     = mem_valid_q;
    assign o_mem_wen       = mem_wen_q;
    assign o_mem_addr      = mem_addr_q;
    assign o_mem_wdata     = mem_wdata_q;
    assign o_mem_wmask     = mem_wmask_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_lsu_core.sv
// Bench for lsu_core: a 32-bit and a 64-bit instance share stimulus; a
// byte-level reference model predicts bus image, load result and timing.
module tb_lsu_core;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic valid32, valid64, wren, mem_ready, mem_rvalid, sel;
  logic [2:0] f3;
  logic [31:0] addr;
  logic [63:0] wdata, mem_rdata;

  logic r32_ready, r32_done, r32_err, r32_mvalid, r32_wen;
  logic [31:0] r32_rdata, r32_maddr, r32_wdata;
  logic [3:0] r32_wmask;
  logic [1:0] r32_code, r32_dbg;
  logic r64_ready, r64_done, r64_err, r64_mvalid, r64_wen;
  logic [63:0] r64_rdata, r64_wdata;
  logic [31:0] r64_maddr;
  logic [7:0] r64_wmask;
  logic [1:0] r64_code, r64_dbg;

  logic ob_ready, ob_done, ob_err, ob_mvalid, ob_wen;
  logic [63:0] ob_rdata, ob_wdata, ob_wmask;
  logic [31:0] ob_maddr;
  logic [1:0] ob_code, ob_dbg;

  int total = 0;
  int bad = 0;
  logic [63:0] last_rd[2];

  // clock / reset
  always #5 clk = ~clk;

  lsu_core #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_idu_req_valid(valid32), .o_lsu_req_ready(r32_ready),
    .i_idu_wren(wren), .i_idu_funct3(f3), .i_exu_addr(addr), .i_idu_wdata(wdata[31:0]),
    .o_lsu_done(r32_done), .o_lsu_rdata(r32_rdata), .o_lsu_err(r32_err),
    .o_lsu_err_code(r32_code), .o_mem_valid(r32_mvalid), .i_mem_ready(mem_ready),
    .o_mem_wen(r32_wen), .o_mem_addr(r32_maddr), .o_mem_wdata(r32_wdata),
    .o_mem_wmask(r32_wmask), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata[31:0]),
    .o_dbg_state(r32_dbg));

  lsu_core #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TMO)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_idu_req_valid(valid64), .o_lsu_req_ready(r64_ready),
    .i_idu_wren(wren), .i_idu_funct3(f3), .i_exu_addr(addr), .i_idu_wdata(wdata),
    .o_lsu_done(r64_done), .o_lsu_rdata(r64_rdata), .o_lsu_err(r64_err),
    .o_lsu_err_code(r64_code), .o_mem_valid(r64_mvalid), .i_mem_ready(mem_ready),
    .o_mem_wen(r64_wen), .o_mem_addr(r64_maddr), .o_mem_wdata(r64_wdata),
    .o_mem_wmask(r64_wmask), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_dbg_state(r64_dbg));

  always_comb begin
    if (sel) begin
      ob_ready = r64_ready; ob_done = r64_done; ob_err = r64_err; ob_code = r64_code;
      ob_mvalid = r64_mvalid; ob_wen = r64_wen; ob_maddr = r64_maddr; ob_dbg = r64_dbg;
      ob_rdata = r64_rdata; ob_wdata = r64_wdata; ob_wmask = {56'b0, r64_wmask};
    end else begin
      ob_ready = r32_ready; ob_done = r32_done; ob_err = r32_err; ob_code = r32_code;
      ob_mvalid = r32_mvalid; ob_wen = r32_wen; ob_maddr = r32_maddr; ob_dbg = r32_dbg;
      ob_rdata = {32'b0, r32_rdata}; ob_wdata = {32'b0, r32_wdata}; ob_wmask = {60'b0, r32_wmask};
    end
  end

  // scoreboard comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: byte-by-byte view of the access
  function automatic logic [63:0] model_load(int nb, logic [2:0] fn, logic [31:0] a, logic [63:0] word);
    int off;
    int size;
    logic [63:0] v;
    off = int'(a % nb);
    size = 1 << fn[1:0];
    v = '0;
    for (int b = 0; b < size; b++)
      if (off + b < nb) v[8*b +: 8] = word[8*(off+b) +: 8];
    if (!fn[2] && size < 8 && v[8*size-1])
      for (int b = size; b < 8; b++) v[8*b +: 8] = 8'hFF;
    if (nb == 4) v[63:32] = '0;
    return v;
  endfunction

  function automatic logic [63:0] model_wmask(int nb, bit w, logic [2:0] fn, logic [31:0] a);
    int off;
    int size;
    logic [63:0] m;
    off = int'(a % nb);
    size = 1 << fn[1:0];
    m = '0;
    if (w)
      for (int b = 0; b < nb; b++)
        if (b >= off && b < off + size) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(int nb, logic [31:0] a, logic [63:0] wd);
    int off;
    logic [63:0] v;
    off = int'(a % nb);
    v = '0;
    for (int b = 0; b < nb; b++)
      if (b >= off) v[8*b +: 8] = wd[8*(b-off) +: 8];
    return v;
  endfunction

  // driver + memory responder for one request, checked against the model
  task automatic run_txn(input bit s, input bit w, input logic [2:0] fn, input logic [31:0] a,
                         input logic [63:0] wd, input int rd, input int vd, input logic [63:0] rdat,
                         input bit stall, input bit early);
    int nb, off, size, exp_k, k, done_k, ready_k, vcnt;
    bit ill, mis, bus, seen;
    logic [1:0] ecode;
    logic [63:0] exp_rd;
    nb = s ? 8 : 4;
    off = int'(a % nb);
    size = 1 << fn[1:0];
    ill = (fn == 3'd7) || (fn == 3'd3 && nb == 4) || (fn == 3'd6 && nb == 4) || (w && fn[2]);
    mis = !ill && ((a % size) != 0);
    bus = !ill && !mis;
    ecode = ill ? 2'b11 : mis ? 2'b01 : stall ? 2'b10 : 2'b00;
    exp_k = !bus ? 1 : stall ? 1 + TMO : 3 + rd + vd;
    exp_rd = (bus && !w && !stall) ? model_load(nb, fn, a, rdat) : last_rd[s];
    sel = s;
    @(negedge clk);
    chk("req_ready", ob_ready, 1);
    if (s) valid64 = 1'b1; else valid32 = 1'b1;
    wren = w; f3 = fn; addr = a; wdata = wd; mem_rdata = rdat;
    @(negedge clk);
    valid32 = 1'b0; valid64 = 1'b0;
    chk("busy_ready", ob_ready, 0);
    k = 1; done_k = -1; ready_k = -1; vcnt = 0; seen = 0;
    while (done_k < 0 && k <= 40) begin
      if (ob_mvalid) begin
        vcnt++;
        if (!seen) begin
          seen = 1;
          chk("mem_addr", ob_maddr, a - 32'(off));
          chk("mem_wen", ob_wen, w);
          chk("mem_wmask", ob_wmask, model_wmask(nb, w, fn, a));
          if (w) chk("mem_wdata", ob_wdata, model_wdata(nb, a, wd));
        end
      end
      if (ob_done) begin
        done_k = k;
        chk("err", ob_err, ecode != 2'b00);
        chk("err_code", ob_code, ecode);
        chk("rdata", ob_rdata, exp_rd);
        chk("done_mvalid", ob_mvalid, 0);
      end
      mem_rvalid = (ready_k >= 0) && (k == ready_k + 1 + vd);
      mem_ready = (ready_k < 0) && !stall && ob_mvalid && (k >= 1 + rd);
      if (mem_ready) begin
        ready_k = k;
        if (early) mem_rvalid = 1'b1;
      end
      @(negedge clk);
      k++;
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    chk("done_cycle", done_k, exp_k);
    chk("bus_beats", vcnt, bus ? (stall ? TMO : 1 + rd) : 0);
    chk("done_pulse", ob_done, 0);
    chk("ready_again", ob_ready, 1);
    last_rd[s] = exp_rd;
  endtask

  task automatic chk_zero(input bit s);
    sel = s;
    #1;
    chk("z_done", ob_done, 0);
    chk("z_ready", ob_ready, 0);
    chk("z_rdata", ob_rdata, 0);
    chk("z_err", ob_err, 0);
    chk("z_code", ob_code, 0);
    chk("z_mvalid", ob_mvalid, 0);
    chk("z_wen", ob_wen, 0);
    chk("z_maddr", ob_maddr, 0);
    chk("z_wdata", ob_wdata, 0);
    chk("z_wmask", ob_wmask, 0);
    chk("z_dbg", ob_dbg, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit s, w;
    logic [2:0] fn;
    logic [31:0] a;
    int nb, size, off;
    rst = 1'b1; valid32 = 0; valid64 = 0; wren = 0; f3 = 0; addr = 0; wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; sel = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (3) @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    rst = 1'b0;
    @(negedge clk);
    sel = 0; #1 chk("rel_ready32", ob_ready, 1);
    sel = 1; #1 chk("rel_ready64", ob_ready, 1);

    // LB / LBU sign and zero extension
    run_txn(0, 0, 3'b000, 32'h8000_0003, 64'h0, 0, 0, 64'h80FF_1234, 0, 0);
    chk("lb_value", ob_rdata, 64'hFFFF_FF80);
    run_txn(0, 0, 3'b100, 32'h8000_0003, 64'h0, 0, 0, 64'h80FF_1234, 0, 0);
    chk("lbu_value", ob_rdata, 64'h0000_0080);
    // SH upper half with 4-cycle ack stall
    run_txn(0, 1, 3'b001, 32'h8000_0002, 64'h0000_ABCD, 0, 4, 64'h0, 0, 0);
    chk("sh_rdata_hold", ob_rdata, 64'h0000_0080);
    // misaligned and illegal width
    run_txn(0, 0, 3'b010, 32'h8000_0006, 64'h0, 0, 0, 64'h0, 0, 0);
    run_txn(0, 0, 3'b011, 32'h8000_0000, 64'h0, 0, 0, 64'h0, 0, 0);
    run_txn(0, 1, 3'b100, 32'h8000_0000, 64'h0, 0, 0, 64'h0, 0, 0);
    run_txn(0, 0, 3'b111, 32'h8000_0000, 64'h0, 0, 0, 64'h0, 0, 0);
    // timeout, then a late response that must be ignored
    run_txn(0, 0, 3'b010, 32'h8000_0000, 64'h0, 0, 0, 64'h1234_5678, 1, 0);
    @(negedge clk);
    @(negedge clk);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stray_done", ob_done, 0);
    chk("stray_ready", ob_ready, 1);
    chk("stray_rdata", ob_rdata, 64'h0000_0080);
    run_txn(0, 0, 3'b010, 32'h8000_0010, 64'h0, 1, 2, 64'h1122_3344, 0, 0);
    chk("lw_after_tmo", ob_rdata, 64'h1122_3344);
    // ready and rvalid together in REQ: response must come later
    run_txn(0, 0, 3'b001, 32'h8000_0002, 64'h0, 1, 1, 64'h8001_0000, 0, 1);
    chk("lh_early", ob_rdata, 64'hFFFF_8001);

    // reset pulsed during WAIT
    sel = 0;
    @(negedge clk);
    valid32 = 1'b1; wren = 0; f3 = 3'b010; addr = 32'h8000_0020; mem_rdata = 64'h5555_AAAA;
    @(negedge clk);
    valid32 = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("wait_mvalid", ob_mvalid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_zero(0);
    rst = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rst_no_done", ob_done, 0);
    chk("rst_ready", ob_ready, 1);
    chk("rst_rdata", ob_rdata, 0);
    last_rd[0] = '0; last_rd[1] = '0;

    // 64-bit data path
    run_txn(1, 0, 3'b010, 32'h8000_0004, 64'h0, 0, 0, 64'h8000_0000_1234_5678, 0, 0);
    chk("lw64_value", ob_rdata, 64'hFFFF_FFFF_8000_0000);
    run_txn(1, 0, 3'b110, 32'h8000_0004, 64'h0, 0, 1, 64'h8000_0000_1234_5678, 0, 0);
    chk("lwu64_value", ob_rdata, 64'h0000_0000_8000_0000);
    run_txn(1, 1, 3'b011, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 2, 0, 64'h0, 0, 0);
    run_txn(1, 0, 3'b011, 32'h8000_0008, 64'h0, 0, 0, 64'hDEAD_BEEF_0BAD_F00D, 0, 0);
    chk("ld64_value", ob_rdata, 64'hDEAD_BEEF_0BAD_F00D);
    run_txn(1, 0, 3'b011, 32'h8000_000C, 64'h0, 0, 0, 64'h0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      fn = 3'($urandom_range(0, 7));
      nb = s ? 8 : 4;
      size = 1 << fn[1:0];
      if ($urandom_range(0, 3) == 0) off = int'($urandom_range(0, nb - 1));
      else off = (int'($urandom_range(0, nb - 1)) / size) * size;
      a = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 8 + 32'(off);
      run_txn(s, w, fn, a, {$urandom, $urandom}, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), {$urandom, $urandom}, 0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
